// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Contents:
//   rx_state_t   - receiver frame state
//   PAR_EVEN/ODD - parity sense selectors
//   parity_calc  - expected parity bit for a data word (zero-extended to 9 bits)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit the transmitter must send so that XOR(data, bit) == odd.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rcv_cfg_if.sv
// Receiver-to-consumer bundle: serial line in, received word and status out.
// Signals:
//   RX       - asynchronous serial line, idle high
//   clr_rdy  - consumer ack, clears rdy and all error flags
//   rx_data  - last received data word
//   rdy      - unacknowledged frame available
//   frm_err  - sticky framing error
//   par_err  - sticky parity error
//   ovr_err  - sticky overrun error
//   busy     - receiver is inside a frame
// Modports: master = line driver / consumer side, slave = receiver.
interface uart_rcv_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 RX;
    logic                 clr_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 frm_err;
    logic                 par_err;
    logic                 ovr_err;
    logic                 busy;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err,
        input  par_err,
        input  ovr_err,
        input  busy
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err,
        output par_err,
        output ovr_err,
        output busy
    );
endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the RX pin plus start-edge qualification.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   rx_i   - raw asynchronous serial line
//   rx_s_o - synchronized line (second sync flop)
//   fall_o - one-cycle pulse on a 1->0 transition of rx_s_o once armed
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    // The sync flops reset high, so their output reflects the pin only after
    // two clocks; fill_q tracks that so a line held low through reset cannot
    // arm the receiver from the reset value.
    always_comb begin
        sync1_d = rx_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & sync2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign rx_s_o = sync2_q;
    assign fall_o = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rcv_cfg.sv
// Configurable serial receiver: DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits, with framing/parity/overrun flags held until clr_rdy.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - uart_rcv_cfg_if slave: RX, clr_rdy in; rx_data, rdy, errors, busy out
module uart_rcv_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 2604,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input logic           clk,
    input logic           rst,
    uart_rcv_cfg_if.slave bus
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_s;
    logic fall;

    uart_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (bus.RX),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frm_q, frm_d;      // framing error seen in this frame
    logic                 par_q, par_d;      // parity error seen in this frame
    logic                 done_q, done_d;    // final stop sample taken last cycle

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rdy_q, rdy_d;
    logic                 frm_err_q, frm_err_d;
    logic                 par_err_q, par_err_d;
    logic                 ovr_err_q, ovr_err_d;

    // Frame sequencing: the counter runs down to 0, the line is sampled on the
    // cycle it reads 0, and it reloads in that same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        frm_d   = frm_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            if (fall) begin
                state_d = START;
                cnt_d   = HALF_LOAD;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = FULL_LOAD;
            case (state_q)
                START: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                        frm_d   = 1'b0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                PARITY: begin
                    par_d   = (rx_s != parity_calc(9'(shift_q), ODD_SEL));
                    state_d = STOP;
                end
                STOP: begin
                    if (!rx_s) begin
                        frm_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Consumer-facing status. Completion takes priority over clr_rdy; when both
    // coincide the flags describe only the new frame.
    always_comb begin
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        frm_err_d = frm_err_q;
        par_err_d = par_err_q;
        ovr_err_d = ovr_err_q;

        if (done_q) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            frm_err_d = (frm_err_q & ~bus.clr_rdy) | frm_q;
            par_err_d = (par_err_q & ~bus.clr_rdy) | par_q;
            ovr_err_d = (ovr_err_q | rdy_q) & ~bus.clr_rdy;
        end else if (bus.clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
            par_err_d = 1'b0;
            ovr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            frm_q     <= 1'b0;
            par_q     <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            par_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            frm_q     <= frm_d;
            par_q     <= par_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            frm_err_q <= frm_err_d;
            par_err_q <= par_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;
    assign bus.par_err = par_err_q;
    assign bus.ovr_err = ovr_err_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Bench for uart_rcv_cfg: three configurations (8N1, 7E1, 8N2) fed by one
// model transmitter routed to the selected receiver.
module tb_uart_rcv_cfg;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rcv_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rcv_cfg_if #(.DATA_BITS(7)) if_b ();
    uart_rcv_cfg_if #(.DATA_BITS(8)) if_c ();

    uart_rcv_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    uart_rcv_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(PAR_EVEN),
                   .STOP_BITS(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    uart_rcv_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    // Line/ack routing: unselected receivers see an idle line and no ack.
    int   sel      = 0;
    logic tx_line  = 1'b1;
    logic clr_line = 1'b0;
    assign if_a.RX      = (sel == 0) ? tx_line : 1'b1;
    assign if_b.RX      = (sel == 1) ? tx_line : 1'b1;
    assign if_c.RX      = (sel == 2) ? tx_line : 1'b1;
    assign if_a.clr_rdy = (sel == 0) ? clr_line : 1'b0;
    assign if_b.clr_rdy = (sel == 1) ? clr_line : 1'b0;
    assign if_c.clr_rdy = (sel == 2) ? clr_line : 1'b0;

    logic [2:0] rdy_v, frm_v, par_v, ovr_v, busy_v;
    logic [8:0] data_v [3];
    assign rdy_v  = {if_c.rdy, if_b.rdy, if_a.rdy};
    assign frm_v  = {if_c.frm_err, if_b.frm_err, if_a.frm_err};
    assign par_v  = {if_c.par_err, if_b.par_err, if_a.par_err};
    assign ovr_v  = {if_c.ovr_err, if_b.ovr_err, if_a.ovr_err};
    assign busy_v = {if_c.busy, if_b.busy, if_a.busy};
    assign data_v[0] = {1'b0, if_a.rx_data};
    assign data_v[1] = {2'b0, if_b.rx_data};
    assign data_v[2] = {1'b0, if_c.rx_data};

    // Cycle stamp of each rising edge of rdy.
    logic [2:0] rdy_prev = 3'b000;
    int         rise_cyc [3];
    always @(negedge clk) begin
        rdy_prev <= rdy_v;
        for (int i = 0; i < 3; i++) begin
            if (rdy_v[i] && !rdy_prev[i]) rise_cyc[i] <= cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nbits(input int s);
        return (s == 1) ? 7 : 8;
    endfunction
    function automatic int pen(input int s);
        return (s == 1) ? 1 : 0;
    endfunction
    function automatic int nstop(input int s);
        return (s == 2) ? 2 : 1;
    endfunction
    function automatic logic [8:0] dmask(input int s);
        return (s == 1) ? 9'h07F : 9'h0FF;
    endfunction
    function automatic int frame_bits(input int s);
        return nbits(s) + pen(s) + nstop(s);
    endfunction
    // Line-low to rdy: 3 clk sync + edge detect, half a bit to the start
    // centre, the remaining frame bits, then one completion clock.
    function automatic int latency(input int s);
        return 3 + CPB / 2 + CPB * frame_bits(s) + 1;
    endfunction

    // Reference model of the consumer-visible state of each receiver.
    bit         m_rdy [3];
    bit         m_frm [3];
    bit         m_par [3];
    bit         m_ovr [3];
    logic [8:0] m_data [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rdy[i] = 0; m_frm[i] = 0; m_par[i] = 0; m_ovr[i] = 0; m_data[i] = '0;
        end
    endtask
    task automatic model_ack(input int s);
        m_rdy[s] = 0; m_frm[s] = 0; m_par[s] = 0; m_ovr[s] = 0;
    endtask
    task automatic model_frame(input int s, input logic [8:0] d, input bit fe, input bit pe);
        m_ovr[s]  = m_ovr[s] | m_rdy[s];
        m_frm[s]  = m_frm[s] | fe;
        m_par[s]  = m_par[s] | pe;
        m_data[s] = d & dmask(s);
        m_rdy[s]  = 1;
    endtask

    task automatic check_state(input int s, input string nm);
        check({nm, "_rdy"}, rdy_v[s], m_rdy[s]);
        check({nm, "_data"}, data_v[s], m_data[s]);
        check({nm, "_frm"}, frm_v[s], m_frm[s]);
        check({nm, "_par"}, par_v[s], m_par[s]);
        check({nm, "_ovr"}, ovr_v[s], m_ovr[s]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_line  = 1'b1;
            clr_line = 1'b0;
        end
    endtask

    task automatic ack(input int s);
        sel = s;
        @(negedge clk);
        clr_line = 1'b1;
        @(negedge clk);
        clr_line = 1'b0;
        model_ack(s);
    endtask

    // Model transmitter. flip inverts the parity bit, slo[k] drives stop bit k
    // low, clr_at >= 0 pulses clr_rdy at that clock offset into the frame.
    task automatic send(input int s, input logic [8:0] d, input bit flip, input logic [1:0] slo,
                        input int clr_at, output int st);
        bit         bits [$];
        logic [8:0] dm;
        dm = d & dmask(s);
        bits.push_back(1'b0);
        for (int i = 0; i < nbits(s); i++) bits.push_back(dm[i]);
        if (pen(s) != 0) bits.push_back((^dm) ^ flip);
        for (int k = 0; k < nstop(s); k++) bits.push_back(!slo[k]);
        sel = s;
        st  = 0;
        for (int k = 0; k < bits.size() * CPB; k++) begin
            @(negedge clk);
            if (k == 0) st = cyc;
            tx_line = bits[k / CPB];
            if (clr_at >= 0) clr_line = (k == clr_at);
        end
    endtask

    task automatic frame_chk(input int s, input logic [8:0] d, input bit flip,
                             input logic [1:0] slo, input bit lat, input string nm);
        int         st;
        logic [1:0] sm;
        send(s, d, flip, slo, -1, st);
        idle(2);
        sm = (nstop(s) == 2) ? 2'b11 : 2'b01;
        model_frame(s, d, (slo & sm) != 2'b00, flip && (pen(s) != 0));
        check_state(s, nm);
        if (lat) check({nm, "_lat"}, rise_cyc[s], st + latency(s));
    endtask

    typedef struct {
        int         sel;
        logic [8:0] data;
        bit         flip;
        logic [1:0] slo;
        logic [8:0] exp_data;
        bit         exp_frm;
        bit         exp_par;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  st;
        bit  saw_busy, saw_rdy;

        vecs[0] = '{1, 9'h055, 1'b0, 2'b00, 9'h055, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h055, 1'b1, 2'b00, 9'h055, 1'b0, 1'b1};
        vecs[2] = '{2, 9'h0A5, 1'b0, 2'b10, 9'h0A5, 1'b1, 1'b0};
        vecs[3] = '{2, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b1, 1'b0};
        vecs[4] = '{2, 9'h05A, 1'b0, 2'b00, 9'h05A, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h0FF, 1'b0, 2'b00, 9'h07F, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h003, 1'b1, 2'b00, 9'h003, 1'b0, 1'b1};
        vecs[7] = '{0, 9'h0C3, 1'b0, 2'b01, 9'h0C3, 1'b1, 1'b0};

        // Reset state
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_state(s, "reset");
            check("reset_busy", busy_v[s], 1'b0);
        end
        idle(5);

        // 8N1 sweep with ack after each frame
        for (int d = 0; d < 256; d++) begin
            frame_chk(0, 9'(d), 1'b0, 2'b00, 1'b1, "sweep");
            ack(0);
            check("sweep_clr", rdy_v[0], 1'b0);
        end

        // Directed parity / stop-bit vectors
        for (int i = 0; i < 8; i++) begin
            ack(vecs[i].sel);
            idle(2);
            send(vecs[i].sel, vecs[i].data, vecs[i].flip, vecs[i].slo, -1, st);
            idle(2);
            check("vec_rdy", rdy_v[vecs[i].sel], 1'b1);
            check("vec_data", data_v[vecs[i].sel], vecs[i].exp_data);
            check("vec_frm", frm_v[vecs[i].sel], vecs[i].exp_frm);
            check("vec_par", par_v[vecs[i].sel], vecs[i].exp_par);
            check("vec_ovr", ovr_v[vecs[i].sel], 1'b0);
            check("vec_lat", rise_cyc[vecs[i].sel], st + latency(vecs[i].sel));
            ack(vecs[i].sel);
            m_data[vecs[i].sel] = vecs[i].exp_data;
            idle(2);
        end

        // Glitch start bit
        ack(0);
        idle(4);
        saw_busy = 0;
        saw_rdy  = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tx_line = 1'b0;
            if (busy_v[0]) saw_busy = 1;
            if (rdy_v[0]) saw_rdy = 1;
        end
        for (int k = 0; k < CPB / 2 + 3; k++) begin
            @(negedge clk);
            tx_line = 1'b1;
            if (busy_v[0]) saw_busy = 1;
            if (rdy_v[0]) saw_rdy = 1;
        end
        check("glitch_seen", saw_busy, 1'b1);
        check("glitch_rdy", saw_rdy, 1'b0);
        check("glitch_busy", busy_v[0], 1'b0);
        frame_chk(0, 9'h03C, 1'b0, 2'b00, 1'b1, "post_glitch");

        // Overrun, then clr_rdy coinciding with the second completion
        ack(0);
        idle(2);
        send(0, 9'h011, 1'b0, 2'b00, -1, st);
        send(0, 9'h022, 1'b0, 2'b00, -1, st);
        idle(2);
        model_frame(0, 9'h011, 1'b0, 1'b0);
        model_frame(0, 9'h022, 1'b0, 1'b0);
        check_state(0, "ovr");
        ack(0);
        idle(2);
        send(0, 9'h011, 1'b0, 2'b00, -1, st);
        send(0, 9'h022, 1'b0, 2'b00, latency(0) - 1, st);
        idle(2);
        model_ack(0);
        model_frame(0, 9'h022, 1'b0, 1'b0);
        check_state(0, "ovr_clr");

        // Randomized frames against the reference model
        for (int i = 0; i < 60; i++) begin
            int         s;
            logic [8:0] d;
            logic [1:0] slo;
            s   = $urandom_range(0, 2);
            d   = 9'($urandom_range(0, 511));
            slo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1) ack(s);
            frame_chk(s, d, 1'($urandom_range(0, 1)), slo, 1'b0, "rand");
            idle($urandom_range(0, 12));
        end

        // Reset mid-DATA with the line held low through release
        ack(0);
        idle(4);
        sel = 0;
        for (int k = 0; k < CPB * 3 + CPB / 2; k++) begin
            @(negedge clk);
            tx_line = 1'b0;
        end
        check("mid_busy", busy_v[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state(0, "rst_mid");
        saw_busy = 0;
        saw_rdy  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            tx_line = 1'b0;
            if (busy_v[0]) saw_busy = 1;
            if (rdy_v[0]) saw_rdy = 1;
        end
        check("rst_low_busy", saw_busy, 1'b0);
        check("rst_low_rdy", saw_rdy, 1'b0);
        idle(6);
        frame_chk(0, 9'h081, 1'b0, 2'b00, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rcv_cfg.md
Name: uart_rcv_cfg

Overview:
Parametrised serial receiver, the successor to the fixed 8N1 receiver. It supports configurable baud divisor, data width, optional even/odd parity and one or two stop bits. It flags framing, parity and overrun errors and rejects glitch start bits. It sits between the board RX pin and command/packet logic, handshaking through rdy/clr_rdy.

Parameters:
CLK_PER_BIT, 2604, clocks per bit period (50 MHz / 19200 baud); must be >= 8.
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
PARITY_EN, 0, 1 = parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, 1 or 2 stop bits checked.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
RX  input  1  asynchronous serial line, idle high
clr_rdy  input  1  consumer ack; clears rdy and all error flags
rx_data  output  DATA_BITS  last received data word
rdy  output  1  a frame has completed and is unacknowledged
frm_err  output  1  a stop bit was sampled low (sticky until clr_rdy)
par_err  output  1  parity mismatch (sticky until clr_rdy)
ovr_err  output  1  a frame completed while rdy was already 1 (sticky until clr_rdy)
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge): rx_data = 0, rdy = 0, all err = 0, busy = 0, state = IDLE. Sync flops = 1. armed = 0.
- Reset mid-frame aborts the frame with no rdy and no error.
- Input sync: RX passes through two flops, giving 2 clk latency; rx_s is the second flop.
- armed sets on the first cycle rx_s == 1. No start is accepted until armed, so a line held low through reset is ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a falling edge of rx_s while armed; the baud counter loads CLK_PER_BIT/2 - 1.
- START: when the counter hits 0, sample rx_s.
  - rx_s == 1: false start, go to IDLE with no flags.
  - rx_s == 0: go to DATA; counter loads CLK_PER_BIT - 1; bit count = 0.
- DATA: sample at each counter expiry and shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: sample once. Mismatch means XOR(data, parity bit) != PARITY_ODD.
- STOP: sample STOP_BITS times, one bit period apart. Any low sample marks a framing error. After the last sample, go to IDLE in the same cycle.
  - The final stop sample lands at mid-bit, so back-to-back frames are caught.
- Completion cycle (the clock after the final stop sample):
  - rx_data is loaded and rdy = 1.
  - frm_err/par_err are set if the corresponding condition occurred; each is ORed with its current value.
  - ovr_err = 1 if rdy was 1 and clr_rdy = 0 in that cycle.
  - rx_data is overwritten on overrun; the newest data wins.
- Frames with errors still assert rdy and load rx_data.
- clr_rdy: the next cycle has rdy = 0 and all err = 0.
- Simultaneous clr_rdy and completion: completion wins. rdy = 1, flags reflect only the new frame, ovr_err = 0.
- Baud counter width is $clog2(CLK_PER_BIT). Bit counter width is $clog2(DATA_BITS+1). The counter counts down and reloads with no wrap glitch.
- RX changes during START/DATA outside the sample points are ignored; there is no oversampling or voting.

Decomposition:
- Package uart_pkg:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparams PAR_EVEN = 0, PAR_ODD = 1
  - function parity_calc(data, odd)
- One natural sub-module: uart_sync_edge. It holds the 2-flop synchronizer (reset to 1), the armed flag and the falling-edge detect. It outputs rx_s and fall.

Test Plan (bench uses CLK_PER_BIT = 16; drive RX from a parametrised model transmitter):
1. 8N1: send 0x00..0xFF. Each frame must give rdy rising 1 clk after the final stop sample, rx_data matching, and all err = 0. clr_rdy drops rdy the next cycle.
2. DATA_BITS = 7, PARITY_EN = 1, PARITY_ODD = 0: 0x55 with correct parity gives rx_data = 0x55, par_err = 0. The same frame with the parity bit flipped gives par_err = 1 and rdy = 1.
3. STOP_BITS = 2: 0xA5 with the second stop bit driven low gives frm_err = 1, rdy = 1, rx_data = 0xA5.
4. Glitch: pull RX low for 5 clks, then return high. No rdy and busy back to 0 within CLK_PER_BIT/2 + 3 clks. A following 0x3C frame is received correctly.
5. Overrun: send 0x11 and 0x22 back-to-back without clr_rdy. Result is rx_data = 0x22, ovr_err = 1. Assert clr_rdy exactly on the 0x22 completion cycle instead: ovr_err = 0, rdy = 1.
6. Reset: assert rst at mid-DATA with RX held low through release. No start accepted until RX goes high. A subsequent 0x81 frame is received correctly.
